// File: rtl/sif_pkg.sv
// Shared types and constants for the sif serial front end: FSM states, opcode
// encodings, default bus widths and frame lengths.
package sif_pkg;

  localparam int SIF_AW = 16;
  localparam int SIF_DW = 16;
  localparam int CNT_W  = 6;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  // Qualified bits per frame: opcode + address (+ write data)
  localparam int RD_FRAME_LEN = 1 + SIF_AW;
  localparam int WR_FRAME_LEN = 1 + SIF_AW + SIF_DW;

  typedef enum logic [2:0] {
    IDLE,
    OP,
    ADDR,
    DATA,
    ISSUE,
    WAIT_RD,
    SHIFT_OUT
  } state_t;

  function automatic logic [CNT_W-1:0] last_idx(input int w);
    return CNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/sif_shreg.sv
// Left-shifting register with parallel load, serial shift-in and zero-fill
// shift-out; load has priority over shift-in, which has priority over shift-out.
module sif_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_in_en,
  input  logic         sin,
  input  logic         shift_out_en,
  output logic [W-1:0] q
);

  // NOTE: data registers are cleared by reset as well, because the bus outputs
  // they drive must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_in_en) begin
      q <= {q[W-2:0], sin};
    end else if (shift_out_en) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sif_ser_master.sv
// Serial command front end for one sif port: deserialises opcode/address/data,
// issues a one-cycle strobe, and serialises read data back out MSB first.
module sif_ser_master
  import sif_pkg::*;
#(
  parameter int AW = SIF_AW,
  parameter int DW = SIF_DW
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          s_start,
  input  logic          s_bit_vld,
  input  logic          s_bit,
  output logic          s_out_vld,
  output logic          s_out,
  output logic          busy,
  output logic          err,
  output logic          xa_wr_s,
  output logic          xa_rd_s,
  output logic [AW-1:0] xa_addr,
  output logic [DW-1:0] xa_data_wr,
  input  logic [DW-1:0] xa_data_rd
);

  localparam logic [CNT_W-1:0] ADDR_LAST = last_idx(AW);
  localparam logic [CNT_W-1:0] DATA_LAST = last_idx(DW);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op;

  logic             addr_sh;
  logic             data_sh;
  logic             rd_load;
  logic             rd_sh;
  logic [DW-1:0]    rd_q;

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    addr_sh = 1'b0;
    data_sh = 1'b0;
    rd_load = 1'b0;
    rd_sh   = 1'b0;
    if (!s_start) begin
      addr_sh = (state == ADDR) && s_bit_vld;
      data_sh = (state == DATA) && s_bit_vld;
      rd_load = (state == WAIT_RD);
      rd_sh   = (state == SHIFT_OUT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= OP_RD;
      busy      <= 1'b0;
      err       <= 1'b0;
      xa_wr_s   <= 1'b0;
      xa_rd_s   <= 1'b0;
      s_out_vld <= 1'b0;
    end else begin
      err     <= 1'b0;
      xa_wr_s <= 1'b0;
      xa_rd_s <= 1'b0;
      if (s_start) begin
        // A start outside IDLE aborts the current frame; a strobe already
        // registered for ISSUE still goes out this cycle.
        state     <= OP;
        cnt       <= '0;
        busy      <= 1'b1;
        s_out_vld <= 1'b0;
        err       <= (state != IDLE);
      end else begin
        case (state)
          IDLE: ;
          OP: begin
            if (s_bit_vld) begin
              op    <= s_bit;
              state <= ADDR;
              cnt   <= '0;
            end
          end
          ADDR: begin
            if (s_bit_vld) begin
              if (cnt == ADDR_LAST) begin
                cnt <= '0;
                if (op == OP_WR) begin
                  state <= DATA;
                end else begin
                  state   <= ISSUE;
                  xa_rd_s <= 1'b1;
                end
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if (s_bit_vld) begin
              if (cnt == DATA_LAST) begin
                cnt     <= '0;
                state   <= ISSUE;
                xa_wr_s <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          ISSUE: begin
            cnt <= '0;
            if (op == OP_WR) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_RD;
            end
          end
          WAIT_RD: begin
            cnt       <= '0;
            state     <= SHIFT_OUT;
            s_out_vld <= 1'b1;
          end
          SHIFT_OUT: begin
            if (cnt == DATA_LAST) begin
              cnt       <= '0;
              state     <= IDLE;
              busy      <= 1'b0;
              s_out_vld <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  sif_shreg #(.W(AW)) u_addr_sr (
    .clk          (clk),
    .rst_b        (rst_b),
    .load         (1'b0),
    .load_val     ('0),
    .shift_in_en  (addr_sh),
    .sin          (s_bit),
    .shift_out_en (1'b0),
    .q            (xa_addr)
  );

  sif_shreg #(.W(DW)) u_wdata_sr (
    .clk          (clk),
    .rst_b        (rst_b),
    .load         (1'b0),
    .load_val     ('0),
    .shift_in_en  (data_sh),
    .sin          (s_bit),
    .shift_out_en (1'b0),
    .q            (xa_data_wr)
  );

  sif_shreg #(.W(DW)) u_rdata_sr (
    .clk          (clk),
    .rst_b        (rst_b),
    .load         (rd_load),
    .load_val     (xa_data_rd),
    .shift_in_en  (1'b0),
    .sin          (1'b0),
    .shift_out_en (rd_sh),
    .q            (rd_q)
  );

  // Lower read bits reach s_out only by shifting into the MSB position.
  logic unused_rd_bits;
  assign unused_rd_bits = ^rd_q[DW-2:0];

  assign s_out = s_out_vld & rd_q[DW-1];

endmodule

// File: tb/tb_sif_ser_master.sv
// Directed bench for sif_ser_master: table of write/read frames plus hand
// sequences for back-to-back reads, abort and mid-shift reset.
module tb_sif_ser_master;
  import sif_pkg::*;

  logic        clk;
  logic        rst_b;
  logic        s_start;
  logic        s_bit_vld;
  logic        s_bit;
  logic        s_out_vld;
  logic        s_out;
  logic        busy;
  logic        err;
  logic        xa_wr_s;
  logic        xa_rd_s;
  logic [15:0] xa_addr;
  logic [15:0] xa_data_wr;
  logic [15:0] xa_data_rd;

  int errors = 0;
  int checks = 0;
  int n_wr   = 0;
  int n_rd   = 0;
  int n_err  = 0;
  int n_both = 0;

  typedef struct {
    logic        op;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          gaps;
    logic [15:0] exp_rd;
  } vec_t;

  sif_ser_master #(.AW(16), .DW(16)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .s_start    (s_start),
    .s_bit_vld  (s_bit_vld),
    .s_bit      (s_bit),
    .s_out_vld  (s_out_vld),
    .s_out      (s_out),
    .busy       (busy),
    .err        (err),
    .xa_wr_s    (xa_wr_s),
    .xa_rd_s    (xa_rd_s),
    .xa_addr    (xa_addr),
    .xa_data_wr (xa_data_wr),
    .xa_data_rd (xa_data_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the sif port: registered read data valid only the cycle after xa_rd_s.
  function automatic logic [15:0] rd_model(input logic [15:0] a);
    case (a)
      16'h05DE: return 16'h04DE;
      16'h0463: return 16'h04E3;
      16'h1305: return 16'h1305;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  always @(posedge clk) xa_data_rd <= xa_rd_s ? rd_model(xa_addr) : 16'hDEAD;

  always @(negedge clk) begin
    if (xa_wr_s) n_wr++;
    if (xa_rd_s) n_rd++;
    if (err) n_err++;
    if (xa_wr_s && xa_rd_s) n_both++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        s_bit_vld = 1'b0;
        s_bit     = 1'($urandom);
        step();
      end
    end
    s_bit_vld = 1'b1;
    s_bit     = b;
    step();
    s_bit_vld = 1'b0;
  endtask

  // Returns with the clock just past the edge of the first cycle a new s_start may use.
  task automatic run_frame(input vec_t v, input bit with_start);
    logic [15:0] got;
    bit          vld_ok;
    int          wr0;
    int          rd0;
    wr0 = n_wr;
    rd0 = n_rd;
    if (with_start) begin
      s_start = 1'b1;
      step();
      s_start = 1'b0;
    end
    send_bit(v.op, v.gaps);
    for (int i = 15; i >= 0; i--) send_bit(v.addr[i], v.gaps);
    if (v.op) for (int i = 15; i >= 0; i--) send_bit(v.wdata[i], v.gaps);
    if (v.op) begin
      check("wr_strobe", 32'(xa_wr_s), 32'd1);
      check("no_rd_on_wr", 32'(xa_rd_s), 32'd0);
      check("wr_addr", 32'(xa_addr), 32'(v.addr));
      check("wr_data", 32'(xa_data_wr), 32'(v.wdata));
      step();
      check("wr_strobe_len", 32'(xa_wr_s), 32'd0);
      check("busy_after_wr", 32'(busy), 32'd0);
      check("wr_count", 32'(n_wr - wr0), 32'd1);
    end else begin
      check("rd_strobe", 32'(xa_rd_s), 32'd1);
      check("no_wr_on_rd", 32'(xa_wr_s), 32'd0);
      check("rd_addr", 32'(xa_addr), 32'(v.addr));
      step();
      check("wait_rd_vld", 32'({xa_rd_s, s_out_vld}), 32'd0);
      step();
      got    = '0;
      vld_ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (s_out_vld !== 1'b1 || busy !== 1'b1) vld_ok = 1'b0;
        got = {got[14:0], s_out};
        step();
      end
      check("shift_vld_window", 32'(vld_ok), 32'd1);
      check("rd_data", 32'(got), 32'(v.exp_rd));
      check("vld_end", 32'({s_out_vld, busy}), 32'd0);
      check("rd_count", 32'(n_rd - rd0), 32'd1);
    end
  endtask

  vec_t vecs[6];
  vec_t v;
  int   err0;
  int   rd0;

  initial begin
    vecs[0] = '{op: 1'b1, addr: 16'h1234, wdata: 16'hABCD, gaps: 1'b0, exp_rd: 16'h0000};
    vecs[1] = '{op: 1'b0, addr: 16'h05DE, wdata: 16'h0000, gaps: 1'b0, exp_rd: 16'h04DE};
    vecs[2] = '{op: 1'b1, addr: 16'h1234, wdata: 16'hABCD, gaps: 1'b1, exp_rd: 16'h0000};
    vecs[3] = '{op: 1'b1, addr: 16'hFFFF, wdata: 16'h0000, gaps: 1'b0, exp_rd: 16'h0000};
    vecs[4] = '{op: 1'b0, addr: 16'h0000, wdata: 16'h0000, gaps: 1'b1, exp_rd: 16'h5A5A};
    vecs[5] = '{op: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, gaps: 1'b0, exp_rd: 16'hA5A5};

    rst_b     = 1'b0;
    s_start   = 1'b0;
    s_bit_vld = 1'b0;
    s_bit     = 1'b0;
    repeat (3) step();
    check("rst_ctrl", 32'({busy, err, s_out_vld, s_out, xa_wr_s, xa_rd_s}), 32'd0);
    check("rst_addr", 32'(xa_addr), 32'd0);
    check("rst_wdata", 32'(xa_data_wr), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    step();

    // Qualified bits in IDLE must be ignored.
    s_bit_vld = 1'b1;
    s_bit     = 1'b1;
    repeat (3) step();
    s_bit_vld = 1'b0;
    check("idle_ignores_bits", 32'({busy, xa_addr}), 32'd0);

    err0 = n_err;
    for (int i = 0; i < 6; i++) run_frame(vecs[i], 1'b1);

    // Back-to-back reads: second start in the cycle right after the last s_out_vld.
    v = '{op: 1'b0, addr: 16'h0463, wdata: 16'h0000, gaps: 1'b0, exp_rd: 16'h04E3};
    run_frame(v, 1'b1);
    v = '{op: 1'b0, addr: 16'h1305, wdata: 16'h0000, gaps: 1'b0, exp_rd: 16'h1305};
    run_frame(v, 1'b1);
    check("no_err_clean_frames", 32'(n_err - err0), 32'd0);

    // Abort after 9 address bits, then a full read restarting from OP.
    err0 = n_err;
    rd0  = n_rd;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    send_bit(1'b0, 1'b0);
    for (int i = 15; i >= 7; i--) send_bit(vecs[1].addr[i], 1'b0);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    check("abort_err", 32'({err, busy}), 32'b11);
    step();
    check("abort_err_len", 32'(err), 32'd0);
    run_frame(vecs[1], 1'b0);
    check("abort_rd_strobes", 32'(n_rd - rd0), 32'd1);
    check("abort_err_count", 32'(n_err - err0), 32'd1);

    // Reset during SHIFT_OUT, then a normal write and read.
    err0 = n_err;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    send_bit(1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) send_bit(vecs[1].addr[i], 1'b0);
    repeat (4) step();
    check("pre_reset_shifting", 32'({s_out_vld, busy}), 32'b11);
    rst_b = 1'b0;
    #1;
    check("mid_rst_ctrl", 32'({busy, err, s_out_vld, s_out, xa_wr_s, xa_rd_s}), 32'd0);
    check("mid_rst_bus", 32'({xa_addr, xa_data_wr}), 32'd0);
    repeat (2) step();
    @(negedge clk);
    rst_b = 1'b1;
    step();
    check("post_rst_idle", 32'({busy, s_out_vld}), 32'd0);
    run_frame(vecs[0], 1'b1);
    run_frame(vecs[1], 1'b1);
    check("no_err_after_reset", 32'(n_err - err0), 32'd0);
    check("never_both_strobes", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
